// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master sequencer for the LSU's MMIO command registers.
// Issues one write or read per command and reports completion, error code and read data.
module axi_lite_master_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_sel,
    input  logic [1:0]          i_cmd_ctrl,
    input  logic [ADDR_W-1:0]   i_cmd_addr,
    input  logic [DATA_W-1:0]   i_cmd_wdata,
    input  logic [DATA_W/8-1:0] i_cmd_strobe,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_err_code,
    output logic [DATA_W-1:0]   o_rdata,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    // Abort on the last of TIMEOUT cycles spent waiting in a handshake state.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SLAVE   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdData,
        StDone
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             aw_done_q;
    logic             w_done_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, timed_out;

    assign aw_hs     = m_awvalid & m_awready;
    assign w_hs      = m_wvalid & m_wready;
    assign b_hs      = m_bvalid & m_bready;
    assign ar_hs     = m_arvalid & m_arready;
    assign r_hs      = m_rvalid & m_rready;
    assign timed_out = (cnt_q == CNT_LAST);

    function automatic logic [1:0] resp_err(input logic [1:0] resp);
        return (resp != 2'b00) ? ERR_SLAVE : ERR_OK;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err_code <= ERR_OK;
            o_rdata    <= '0;
            m_awaddr   <= '0;
            m_awvalid  <= 1'b0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            m_araddr   <= '0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_cmd_sel) begin
                        case (i_cmd_ctrl)
                            2'b01: begin
                                m_awaddr  <= i_cmd_addr;
                                m_wdata   <= i_cmd_wdata;
                                m_wstrb   <= i_cmd_strobe;
                                m_awvalid <= 1'b1;
                                m_wvalid  <= 1'b1;
                                aw_done_q <= 1'b0;
                                w_done_q  <= 1'b0;
                                cnt_q     <= '0;
                                o_busy    <= 1'b1;
                                state_q   <= StWrReq;
                            end
                            2'b10: begin
                                m_araddr  <= i_cmd_addr;
                                m_arvalid <= 1'b1;
                                cnt_q     <= '0;
                                o_busy    <= 1'b1;
                                state_q   <= StRdReq;
                            end
                            2'b11: begin
                                o_err_code <= ERR_ILLEGAL;
                                o_done     <= 1'b1;
                                o_busy     <= 1'b1;
                                state_q    <= StDone;
                            end
                            default: ;
                        endcase
                    end
                end
                StWrReq: begin
                    if (aw_hs) begin
                        m_awvalid <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        m_wvalid <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    // AW and W may complete in either order or together.
                    if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                        m_bready <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= StWrResp;
                    end else if (timed_out) begin
                        m_awvalid  <= 1'b0;
                        m_wvalid   <= 1'b0;
                        o_err_code <= ERR_TIMEOUT;
                        o_done     <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StWrResp: begin
                    if (b_hs) begin
                        m_bready   <= 1'b0;
                        o_err_code <= resp_err(m_bresp);
                        o_done     <= 1'b1;
                        state_q    <= StDone;
                    end else if (timed_out) begin
                        m_bready   <= 1'b0;
                        o_err_code <= ERR_TIMEOUT;
                        o_done     <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRdReq: begin
                    if (ar_hs) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StRdData;
                    end else if (timed_out) begin
                        m_arvalid  <= 1'b0;
                        o_err_code <= ERR_TIMEOUT;
                        o_done     <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRdData: begin
                    if (r_hs) begin
                        o_rdata    <= m_rdata;
                        o_err_code <= resp_err(m_rresp);
                        m_rready   <= 1'b0;
                        o_done     <= 1'b1;
                        state_q    <= StDone;
                    end else if (timed_out) begin
                        m_rready   <= 1'b0;
                        o_err_code <= ERR_TIMEOUT;
                        o_done     <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Bench for axi_lite_master_ctrl: directed slave timing per scenario, with expected
// waveforms derived from handshake latencies and checked every cycle.
module tb_axi_lite_master_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_sel = 1'b0;
    logic [1:0]  cmd_ctrl = 2'b00;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strobe = '0;
    logic        o_busy, o_done;
    logic [1:0]  o_err_code;
    logic [31:0] o_rdata;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic        m_arready = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
    logic [31:0] m_rdata = '0;

    always #5 clk = ~clk;

    axi_lite_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_cmd_sel(cmd_sel), .i_cmd_ctrl(cmd_ctrl),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_strobe(cmd_strobe),
        .o_busy(o_busy), .o_done(o_done), .o_err_code(o_err_code), .o_rdata(o_rdata),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    typedef enum int {KWr, KRd, KRdTo, KIll} kind_e;

    // Scenario description: slave ready/valid asserted from cycle s_* onward,
    // cycle 0 being the cycle the command is presented.
    kind_e       s_kind = KIll;
    int          s_a, s_w, s_b, s_r, s_rv;
    logic [1:0]  s_resp;
    logic [31:0] s_addr, s_wdata, s_rd;
    logic [3:0]  s_strb;
    bit          s_extra;
    int          done_c;
    logic [1:0]  prev_err = 2'b00, new_err;
    logic [31:0] prev_rdata = '0, new_rdata;
    bit          active = 1'b0;
    int          cyc = -1;
    int          aw_cnt, w_cnt, ar_cnt, done_at;
    int          checks = 0;
    int          failures = 0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against latencies computed from the handshake schedule.
    always @(negedge clk) begin
        if (active) begin
            int t, h, bh, rh;
            bit e_aw, e_w, e_b, e_ar, e_r, e_busy, e_done;
            t = cyc;
            e_aw = 0; e_w = 0; e_b = 0; e_ar = 0; e_r = 0;
            case (s_kind)
                KWr: begin
                    h    = imax(s_a, s_w);
                    bh   = imax(h + 1, s_b);
                    e_aw = (t >= 1 && t <= s_a);
                    e_w  = (t >= 1 && t <= s_w);
                    e_b  = (t >= h + 1 && t <= bh);
                end
                KRd: begin
                    rh   = imax(s_r + 1, s_rv);
                    e_ar = (t >= 1 && t <= s_r);
                    e_r  = (t >= s_r + 1 && t <= rh);
                end
                KRdTo: e_ar = (t >= 1 && t <= TO);
                default: ;
            endcase
            e_busy = (t >= 1 && t <= done_c);
            e_done = (t == done_c);
            check("awvalid", m_awvalid, e_aw);
            check("wvalid", m_wvalid, e_w);
            check("bready", m_bready, e_b);
            check("arvalid", m_arvalid, e_ar);
            check("rready", m_rready, e_r);
            check("busy", o_busy, e_busy);
            check("done", o_done, e_done);
            check("err_code", o_err_code, (t >= done_c) ? new_err : prev_err);
            check("rdata", o_rdata, (t >= done_c) ? new_rdata : prev_rdata);
            if (e_aw) check("awaddr", m_awaddr, s_addr);
            if (e_w) begin
                check("wdata", m_wdata, s_wdata);
                check("wstrb", m_wstrb, s_strb);
            end
            if (e_ar) check("araddr", m_araddr, s_addr);
            if (m_awvalid) aw_cnt++;
            if (m_wvalid) w_cnt++;
            if (m_arvalid) ar_cnt++;
            if (o_done && done_at < 0) done_at = t;
        end
    end

    task automatic drive(input int t);
        cmd_sel = (t == 0) || (s_extra && (t == 3 || t == done_c));
        if (t == 0) begin
            case (s_kind)
                KWr:     cmd_ctrl = 2'b01;
                KIll:    cmd_ctrl = 2'b11;
                default: cmd_ctrl = 2'b10;
            endcase
            cmd_addr   = s_addr;
            cmd_wdata  = s_wdata;
            cmd_strobe = s_strb;
        end else begin
            cmd_ctrl   = 2'b01;
            cmd_addr   = 32'hBAD0_0000;
            cmd_wdata  = 32'h0BAD_0BAD;
            cmd_strobe = 4'h3;
        end
        m_awready = (t >= s_a);
        m_wready  = (t >= s_w);
        m_bvalid  = (t >= s_b);
        m_arready = (t >= s_r);
        m_rvalid  = (t >= s_rv);
        m_bresp   = s_resp;
        m_rresp   = s_resp;
        m_rdata   = s_rd;
    endtask

    task automatic idle_inputs();
        cmd_sel = 0; cmd_ctrl = 2'b00;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    endtask

    // ncyc < 0 runs the whole transaction plus two idle cycles and commits the result.
    task automatic run(input kind_e k, input int a, input int w, input int b, input int r,
                       input int rv, input logic [1:0] resp, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] rd,
                       input bit extra, input int ncyc);
        int last;
        s_kind = k; s_a = a; s_w = w; s_b = b; s_r = r; s_rv = rv; s_resp = resp;
        s_addr = addr; s_wdata = wd; s_strb = strb; s_rd = rd; s_extra = extra;
        case (k)
            KWr:  begin
                done_c    = imax(imax(a, w) + 1, b) + 1;
                new_err   = (resp != 0) ? 2'b01 : 2'b00;
                new_rdata = prev_rdata;
            end
            KRd:  begin
                done_c    = imax(r + 1, rv) + 1;
                new_err   = (resp != 0) ? 2'b01 : 2'b00;
                new_rdata = rd;
            end
            KRdTo: begin
                done_c    = TO + 1;
                new_err   = 2'b10;
                new_rdata = prev_rdata;
            end
            default: begin
                done_c    = 1;
                new_err   = 2'b11;
                new_rdata = prev_rdata;
            end
        endcase
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; done_at = -1;
        last = (ncyc < 0) ? done_c + 2 : ncyc;
        for (int t = 0; t <= last; t++) begin
            @(posedge clk);
            #1;
            cyc    = t;
            active = 1'b1;
            drive(t);
        end
        @(negedge clk);
        #1;
        active = 1'b0;
        idle_inputs();
        if (ncyc < 0) begin
            prev_err   = new_err;
            prev_rdata = new_rdata;
        end
    endtask

    initial begin
        #12;
        check("reset_busy", o_busy, 1'b0);
        check("reset_done", o_done, 1'b0);
        check("reset_err", o_err_code, 2'b00);
        check("reset_rdata", o_rdata, 32'h0);
        check("reset_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: zero-wait write
        run(KWr, 1, 1, 0, 999, 999, 2'b00, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF,
            32'hFFFF_0000, 1'b0, -1);
        check("t1_done_at", done_at, 3);
        check("t1_aw_cycles", aw_cnt, 1);
        check("t1_w_cycles", w_cnt, 1);

        // 3: read, arready delayed, error response still captures data
        run(KRd, 999, 999, 999, 3, 5, 2'b10, 32'h2000_0000, 32'h0, 4'h0,
            32'h0000_00A5, 1'b0, -1);
        check("t3_done_at", done_at, 6);
        check("t3_ar_cycles", ar_cnt, 3);
        check("t3_rdata", o_rdata, 32'h0000_00A5);
        check("t3_err", o_err_code, 2'b01);

        // 2 + 5b: awready late; stray writes while busy and in DONE are ignored
        run(KWr, 6, 1, 0, 999, 999, 2'b00, 32'h3000_0004, 32'h1234_ABCD, 4'h5,
            32'hFFFF_0000, 1'b1, -1);
        check("t2_done_at", done_at, 8);
        check("t2_aw_cycles", aw_cnt, 6);
        check("t2_w_cycles", w_cnt, 1);
        check("t2_rdata_kept", o_rdata, 32'h0000_00A5);
        check("t2_err", o_err_code, 2'b00);

        // 5: illegal command
        run(KIll, 0, 0, 0, 0, 0, 2'b00, 32'h4000_0000, 32'h0, 4'h0, 32'h0, 1'b0, -1);
        check("t5_done_at", done_at, 1);
        check("t5_no_valid", aw_cnt + w_cnt + ar_cnt, 0);
        check("t5_err", o_err_code, 2'b11);

        // 4: read timeout
        run(KRdTo, 999, 999, 999, 999, 999, 2'b00, 32'h5000_0000, 32'h0, 4'h0,
            32'h0, 1'b0, -1);
        check("t4_done_at", done_at, 9);
        check("t4_ar_cycles", ar_cnt, 8);
        check("t4_err", o_err_code, 2'b10);

        // W late, AW first, late bvalid with DECERR
        run(KWr, 2, 4, 7, 999, 999, 2'b11, 32'h6000_0008, 32'hCAFE_F00D, 4'hC,
            32'hFFFF_0000, 1'b0, -1);
        check("t7_done_at", done_at, 8);
        check("t7_err", o_err_code, 2'b01);

        // 6: reset in the middle of WR_RESP
        run(KWr, 1, 1, 20, 999, 999, 2'b00, 32'h7000_0000, 32'h5555_AAAA, 4'hF,
            32'h0, 1'b0, 3);
        #1;
        rst_n = 1'b0;
        #1;
        cyc = -2;
        check("t6_bready_async", m_bready, 1'b0);
        check("t6_busy_async", o_busy, 1'b0);
        check("t6_err_async", o_err_code, 2'b00);
        check("t6_rdata_async", o_rdata, 32'h0);
        prev_err   = 2'b00;
        prev_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(KRd, 999, 999, 999, 1, 2, 2'b00, 32'h8000_0010, 32'h0, 4'h0,
            32'h1234_5678, 1'b0, -1);
        check("t6_done_at", done_at, 3);
        check("t6_rdata", o_rdata, 32'h1234_5678);
        check("t6_err", o_err_code, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
